// File: rtl/rf_read_arbiter.sv
// Register-file read arbiter: buffers operand read requests in a FIFO, issues at most one
// read per bank per cycle with CDB writebacks taking priority, and registers per-bank response tags.
module rf_read_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Push_Valid,
    input  logic        Src1_Valid,
    input  logic [1:0]  Src1_Bank,
    input  logic [2:0]  Src1_Row,
    input  logic [2:0]  Src1_OCID,
    input  logic        Src2_Valid,
    input  logic [1:0]  Src2_Bank,
    input  logic [2:0]  Src2_Row,
    input  logic [2:0]  Src2_OCID,
    input  logic        WriteValid,
    input  logic [1:0]  WriteBank,
    output logic        Full,
    output logic        Empty,
    output logic [3:0]  RdEn,
    output logic [11:0] RdRow,
    output logic [3:0]  RspValid,
    output logic [11:0] RspOCID
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          pend1_q [DEPTH];
    logic [1:0]    bank1_q [DEPTH];
    logic [2:0]    row1_q  [DEPTH];
    logic [2:0]    ocid1_q [DEPTH];
    logic          pend2_q [DEPTH];
    logic [1:0]    bank2_q [DEPTH];
    logic [2:0]    row2_q  [DEPTH];
    logic [2:0]    ocid2_q [DEPTH];

    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [3:0]    rspValid_q;
    logic [11:0]   rspOcid_q;
    logic [11:0]   rspOcid_d;

    logic          push;
    logic          pop;
    logic          iss1;
    logic          iss2;
    logic [3:0]    blocked;

    assign Full     = (count_q == DEPTH_C);
    assign Empty    = (count_q == '0);
    assign push     = Push_Valid & (Src1_Valid | Src2_Valid) & ~Full;
    assign RspValid = rspValid_q;
    assign RspOCID  = rspOcid_q;

    always_comb begin
        blocked = '0;
        if (WriteValid) begin
            blocked[WriteBank] = 1'b1;
        end
    end

    // Head-only issue: Src1 gets first claim on its bank, Src2 must avoid Src1's bank.
    always_comb begin
        iss1      = ~Empty & pend1_q[rdPtr_q] & ~blocked[bank1_q[rdPtr_q]];
        iss2      = ~Empty & pend2_q[rdPtr_q] & ~blocked[bank2_q[rdPtr_q]]
                    & ~(iss1 & (bank1_q[rdPtr_q] == bank2_q[rdPtr_q]));
        pop       = ~Empty & (iss1 | iss2)
                    & ~(pend1_q[rdPtr_q] & ~iss1) & ~(pend2_q[rdPtr_q] & ~iss2);
        RdEn      = '0;
        RdRow     = '0;
        rspOcid_d = rspOcid_q;
        for (int b = 0; b < 4; b++) begin
            if (iss1 && (bank1_q[rdPtr_q] == 2'(b))) begin
                RdEn[b]            = 1'b1;
                RdRow[3*b +: 3]    = row1_q[rdPtr_q];
                rspOcid_d[3*b +: 3] = ocid1_q[rdPtr_q];
            end
            if (iss2 && (bank2_q[rdPtr_q] == 2'(b))) begin
                RdEn[b]            = 1'b1;
                RdRow[3*b +: 3]    = row2_q[rdPtr_q];
                rspOcid_d[3*b +: 3] = ocid2_q[rdPtr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            rspValid_q <= '0;
            rspOcid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pend1_q[i] <= 1'b0;
                pend2_q[i] <= 1'b0;
            end
        end else begin
            if (iss1) begin
                pend1_q[rdPtr_q] <= 1'b0;
            end
            if (iss2) begin
                pend2_q[rdPtr_q] <= 1'b0;
            end
            // Push never targets the head slot being issued: equal pointers mean empty or full.
            if (push) begin
                pend1_q[wrPtr_q] <= Src1_Valid;
                bank1_q[wrPtr_q] <= Src1_Bank;
                row1_q[wrPtr_q]  <= Src1_Row;
                ocid1_q[wrPtr_q] <= Src1_OCID;
                pend2_q[wrPtr_q] <= Src2_Valid;
                bank2_q[wrPtr_q] <= Src2_Bank;
                row2_q[wrPtr_q]  <= Src2_Row;
                ocid2_q[wrPtr_q] <= Src2_OCID;
                wrPtr_q          <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            rspValid_q <= RdEn;
            rspOcid_q  <= rspOcid_d;
        end
    end
endmodule

// File: tb/tb_rf_read_arbiter.sv
// Self-checking bench for rf_read_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_rf_read_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Push_Valid = 1'b0;
    logic        Src1_Valid = 1'b0, Src2_Valid = 1'b0;
    logic [1:0]  Src1_Bank = '0, Src2_Bank = '0;
    logic [2:0]  Src1_Row = '0, Src2_Row = '0;
    logic [2:0]  Src1_OCID = '0, Src2_OCID = '0;
    logic        WriteValid = 1'b0;
    logic [1:0]  WriteBank = '0;
    logic        Full, Empty;
    logic [3:0]  RdEn, RspValid;
    logic [11:0] RdRow, RspOCID;

    rf_read_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .Push_Valid(Push_Valid),
        .Src1_Valid(Src1_Valid), .Src1_Bank(Src1_Bank), .Src1_Row(Src1_Row), .Src1_OCID(Src1_OCID),
        .Src2_Valid(Src2_Valid), .Src2_Bank(Src2_Bank), .Src2_Row(Src2_Row), .Src2_OCID(Src2_OCID),
        .WriteValid(WriteValid), .WriteBank(WriteBank),
        .Full(Full), .Empty(Empty), .RdEn(RdEn), .RdRow(RdRow),
        .RspValid(RspValid), .RspOCID(RspOCID)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       p1;
        bit [1:0] b1;
        bit [2:0] r1;
        bit [2:0] o1;
        bit       p2;
        bit [1:0] b2;
        bit [2:0] r2;
        bit [2:0] o2;
    } entry_t;

    entry_t     modelQ[$];
    bit         modelKnown = 1'b0;
    logic [3:0] mRspValid = '0;
    logic [2:0] mRspOcid [4] = '{default: '0};

    int compared   = 0;
    int mismatched = 0;

    logic        obsFull, obsEmpty;
    logic [3:0]  obsRdEn, obsRspValid;
    logic [11:0] obsRdRow, obsRspOcid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at negedge, sample and compare against the model, then advance the model.
    task automatic applyStimulus(input bit rstN, input bit pv,
                                 input bit v1, input bit [1:0] b1, input bit [2:0] r1, input bit [2:0] o1,
                                 input bit v2, input bit [1:0] b2, input bit [2:0] r2, input bit [2:0] o2,
                                 input bit wv, input bit [1:0] wb);
        entry_t      h;
        entry_t      n;
        bit          i1, i2;
        int          sizeBefore;
        logic [3:0]  blk, eEn;
        logic [11:0] eRow, rowMask, eOcid;
        @(negedge clk);
        rst = rstN; Push_Valid = pv;
        Src1_Valid = v1; Src1_Bank = b1; Src1_Row = r1; Src1_OCID = o1;
        Src2_Valid = v2; Src2_Bank = b2; Src2_Row = r2; Src2_OCID = o2;
        WriteValid = wv; WriteBank = wb;
        #1;
        obsFull = Full; obsEmpty = Empty; obsRdEn = RdEn; obsRdRow = RdRow;
        obsRspValid = RspValid; obsRspOcid = RspOCID;

        blk = wv ? (4'b0001 << wb) : 4'b0000;
        eEn = '0; eRow = '0; rowMask = '1; i1 = 0; i2 = 0;
        if (modelQ.size() > 0) begin
            h = modelQ[0];
            rowMask = '0;
            i1 = h.p1 && !blk[h.b1];
            i2 = h.p2 && !blk[h.b2] && !(i1 && h.b1 == h.b2);
            if (i1) begin eEn[h.b1] = 1'b1; eRow[h.b1*3 +: 3] = h.r1; rowMask[h.b1*3 +: 3] = 3'b111; end
            if (i2) begin eEn[h.b2] = 1'b1; eRow[h.b2*3 +: 3] = h.r2; rowMask[h.b2*3 +: 3] = 3'b111; end
        end
        eOcid = {mRspOcid[3], mRspOcid[2], mRspOcid[1], mRspOcid[0]};
        if (modelKnown) begin
            checkOutput("RdEn", obsRdEn, eEn);
            checkOutput("RdRow", obsRdRow & rowMask, eRow);
            checkOutput("Full", obsFull, modelQ.size() == DEPTH);
            checkOutput("Empty", obsEmpty, modelQ.size() == 0);
            checkOutput("RspValid", obsRspValid, mRspValid);
            checkOutput("RspOCID", obsRspOcid, eOcid);
        end

        if (!rstN) begin
            modelQ.delete();
            mRspValid = '0;
            for (int b = 0; b < 4; b++) mRspOcid[b] = '0;
            modelKnown = 1'b1;
        end else begin
            mRspValid = eEn;
            sizeBefore = modelQ.size();
            if (sizeBefore > 0) begin
                if (i1) begin mRspOcid[h.b1] = h.o1; h.p1 = 0; end
                if (i2) begin mRspOcid[h.b2] = h.o2; h.p2 = 0; end
                modelQ[0] = h;
                if (!h.p1 && !h.p2) void'(modelQ.pop_front());
            end
            if (pv && (v1 || v2) && sizeBefore < DEPTH) begin
                n = '{p1: v1, b1: b1, r1: r1, o1: o1, p2: v2, b2: b2, r2: r2, o2: o2};
                modelQ.push_back(n);
            end
        end
    endtask

    task automatic idleCycle(input bit wv, input bit [1:0] wb);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, wv, wb);
    endtask

    task automatic singlePushScenario(input string tag);
        applyStimulus(1, 1, 1, 2'd0, 3'd3, 3'd0, 1, 2'd1, 3'd5, 3'd1, 0, 0);
        checkOutput({tag, "_push_empty"}, obsEmpty, 1);
        idleCycle(0, 0);
        checkOutput({tag, "_rden"}, obsRdEn, 4'b0011);
        checkOutput({tag, "_row0"}, obsRdRow[2:0], 3);
        checkOutput({tag, "_row1"}, obsRdRow[5:3], 5);
        idleCycle(0, 0);
        checkOutput({tag, "_rspvalid"}, obsRspValid, 4'b0011);
        checkOutput({tag, "_ocid0"}, obsRspOcid[2:0], 0);
        checkOutput({tag, "_ocid1"}, obsRspOcid[5:3], 1);
        checkOutput({tag, "_empty"}, obsEmpty, 1);
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycle(0, 0);
        checkOutput("rst_empty", obsEmpty, 1);
        checkOutput("rst_full", obsFull, 0);
        checkOutput("rst_rden", obsRdEn, 0);
        checkOutput("rst_rdrow", obsRdRow, 0);
        checkOutput("rst_rspvalid", obsRspValid, 0);
        checkOutput("rst_rspocid", obsRspOcid, 0);

        singlePushScenario("single");

        // Same-bank pair: two consecutive reads on bank 2, pop after the second.
        applyStimulus(1, 1, 1, 2'd2, 3'd1, 3'd2, 1, 2'd2, 3'd4, 3'd3, 0, 0);
        idleCycle(0, 0);
        checkOutput("conf_rden1", obsRdEn, 4'b0100);
        checkOutput("conf_row1", obsRdRow[8:6], 1);
        idleCycle(0, 0);
        checkOutput("conf_rden2", obsRdEn, 4'b0100);
        checkOutput("conf_row2", obsRdRow[8:6], 4);
        checkOutput("conf_notempty", obsEmpty, 0);
        idleCycle(0, 0);
        checkOutput("conf_empty", obsEmpty, 1);

        applyStimulus(1, 1, 1, 2'd1, 3'd2, 3'd4, 1, 2'd3, 3'd6, 3'd5, 0, 0);
        idleCycle(1, 2'd1);
        checkOutput("wprio_first", obsRdEn, 4'b1000);
        idleCycle(1, 2'd1);
        checkOutput("wprio_stall1", obsRdEn, 4'b0000);
        idleCycle(1, 2'd1);
        checkOutput("wprio_stall2", obsRdEn, 4'b0000);
        idleCycle(0, 0);
        checkOutput("wprio_release", obsRdEn, 4'b0010);
        checkOutput("wprio_row", obsRdRow[5:3], 2);
        idleCycle(0, 0);
        checkOutput("wprio_empty", obsEmpty, 1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1, 2'd0, 3'(i), 3'(i + 1), 0, 0, 0, 0, 1, 2'd0);
        end
        checkOutput("fill_full", obsFull, 1);
        for (int i = 0; i < 4; i++) begin
            idleCycle(0, 0);
            checkOutput("drain_rden", obsRdEn, 4'b0001);
            checkOutput("drain_row", obsRdRow[2:0], i);
        end
        idleCycle(0, 0);
        checkOutput("drain_empty", obsEmpty, 1);
        checkOutput("drain_last_ocid", obsRspOcid[2:0], 4);

        applyStimulus(1, 1, 0, 2'd0, 3'd0, 3'd0, 1, 2'd3, 3'd7, 3'd6, 0, 0);
        idleCycle(0, 0);
        checkOutput("src2only_rden", obsRdEn, 4'b1000);
        checkOutput("src2only_row", obsRdRow[11:9], 7);
        applyStimulus(1, 1, 0, 2'd1, 3'd1, 3'd1, 0, 2'd2, 3'd2, 3'd2, 0, 0);
        idleCycle(0, 0);
        checkOutput("noop_empty", obsEmpty, 1);
        checkOutput("noop_rden", obsRdEn, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 2'd2, 3'(i), 3'(i), 0, 0, 0, 0, 1, 2'd2);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstmid_issue", obsRdEn, 4'b0100);
        idleCycle(0, 0);
        checkOutput("rstmid_empty", obsEmpty, 1);
        checkOutput("rstmid_rden", obsRdEn, 0);
        checkOutput("rstmid_rspvalid", obsRspValid, 0);
        singlePushScenario("repush");

        for (int c = 0; c < 800; c++) begin
            applyStimulus($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
                          1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
                          1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
                          $urandom_range(0, 2) == 0, 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
